// File: rtl/scie_fir_pkg.sv
// scie_fir_pkg: shared opcodes, decode field positions, pipeline tag type and accumulator sizing
package scie_fir_pkg;
   localparam logic [6:0] OP_SET_COEF = 7'h0B;
   localparam logic [6:0] OP_PUSH     = 7'h2B;
   localparam logic [6:0] OP_READ     = 7'h5B;
   localparam logic [6:0] OP_CLEAR    = 7'h7B;
   localparam int CH_LSB = 12;
   localparam int CH_MSB = 14;
   typedef struct packed {
      logic       valid;
      logic [2:0] ch;
   } pipe_tag_t;
   function automatic int acc_w(input int xlen, input int taps);
      return 2 * xlen + $clog2(taps);
   endfunction
endpackage

// File: rtl/scie_fir_mac.sv
// scie_fir_mac: product register stage followed by sum, arithmetic shift and optional saturation
module scie_fir_mac
   import scie_fir_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int TAPS     = 5,
   parameter int SHIFT    = 0,
   parameter int SATURATE = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      i_push,
   input  logic [2:0]                i_ch,
   input  logic [TAPS-1:0][XLEN-1:0] i_coef,
   input  logic [TAPS-1:0][XLEN-1:0] i_x,
   input  logic                      i_inv,
   input  logic [2:0]                i_inv_ch,
   output logic                      o_valid,
   output logic [2:0]                o_ch,
   output logic [XLEN-1:0]           o_result
);
   localparam int AW = acc_w(XLEN, TAPS);
   pipe_tag_t                    r_tag;
   logic [TAPS-1:0][2*XLEN-1:0]  r_prod;
   logic signed [AW-1:0]         w_acc;
   logic signed [AW-1:0]         w_sh;
   logic                         w_fits;
   always_ff @(posedge clock) begin
      if (reset) begin
         r_tag  <= '0;
         r_prod <= '0;
      end else begin
         r_tag <= '{valid: i_push, ch: i_ch};
         for (int t = 0; t < TAPS; t++) r_prod[t] <= $signed(i_coef[t]) * $signed(i_x[t]);
      end
   end
   always_comb begin
      w_acc = '0;
      for (int t = 0; t < TAPS; t++) w_acc = w_acc + AW'($signed(r_prod[t]));
   end
   assign w_sh    = w_acc >>> SHIFT;
   // value fits when every bit above the result sign bit copies it
   assign w_fits  = (&w_sh[AW-1:XLEN-1]) | ~(|w_sh[AW-1:XLEN-1]);
   assign o_result = (SATURATE == 0 || w_fits) ? w_sh[XLEN-1:0]
                   : (w_sh[AW-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}});
   assign o_valid = r_tag.valid && !(i_inv && i_inv_ch == r_tag.ch);
   assign o_ch    = r_tag.ch;
endmodule

// File: rtl/scie_fir_mc.sv
// scie_fir_mc: multi-channel FIR custom-instruction unit; decode, per-channel storage and read port
module scie_fir_mc
   import scie_fir_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int TAPS     = 5,
   parameter int CHANNELS = 2,
   parameter int SHIFT    = 0,
   parameter int SATURATE = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            io_valid,
   input  logic [31:0]     io_insn,
   input  logic [XLEN-1:0] io_rs1,
   input  logic [XLEN-1:0] io_rs2,
   output logic [XLEN-1:0] io_rd
);
   logic [TAPS-1:0][XLEN-1:0] r_coef [CHANNELS];
   logic [TAPS-1:0][XLEN-1:0] r_line [CHANNELS];
   logic [XLEN-1:0]           r_res  [CHANNELS];
   logic [XLEN-1:0]           r_rd;
   logic [6:0]                w_op;
   logic [2:0]                w_ch;
   logic                      w_ok, w_push, w_clear, w_mvalid, w_unused;
   logic [2:0]                w_mch;
   logic [XLEN-1:0]           w_mres;
   logic [TAPS-1:0][XLEN-1:0] w_coef_sel, w_xnew;
   assign w_op     = io_insn[6:0];
   assign w_ch     = io_insn[CH_MSB:CH_LSB];
   assign w_ok     = io_valid && 32'(w_ch) < CHANNELS;
   assign w_push   = w_ok && w_op == OP_PUSH;
   assign w_clear  = w_ok && w_op == OP_CLEAR;
   assign w_unused = ^{io_insn[31:CH_MSB+1], io_insn[CH_LSB-1:7]};
   assign io_rd    = r_rd;
   // post-shift line of the addressed channel feeds the multipliers
   always_comb begin
      w_coef_sel = '0;
      w_xnew     = '0;
      w_xnew[0]  = io_rs1;
      for (int c = 0; c < CHANNELS; c++) begin
         if (w_ch == 3'(c)) begin
            w_coef_sel = r_coef[c];
            for (int t = 1; t < TAPS; t++) w_xnew[t] = r_line[c][t-1];
         end
      end
   end
   scie_fir_mac #(.XLEN(XLEN), .TAPS(TAPS), .SHIFT(SHIFT), .SATURATE(SATURATE)) u_mac (
      .clock    (clock),
      .reset    (reset),
      .i_push   (w_push),
      .i_ch     (w_ch),
      .i_coef   (w_coef_sel),
      .i_x      (w_xnew),
      .i_inv    (w_clear),
      .i_inv_ch (w_ch),
      .o_valid  (w_mvalid),
      .o_ch     (w_mch),
      .o_result (w_mres)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_coef[c] <= '0;
            r_line[c] <= '0;
            r_res[c]  <= '0;
         end
         r_rd <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (io_valid && w_ch == 3'(c)) begin
               if (w_op == OP_SET_COEF)
                  for (int t = 0; t < TAPS; t++) if (io_rs2 == XLEN'(t)) r_coef[c][t] <= io_rs1;
               if (w_op == OP_PUSH) r_line[c] <= w_xnew;
               if (w_op == OP_CLEAR) r_line[c] <= '0;
               if (w_op == OP_READ) r_rd <= r_res[c];
            end
            if (w_clear && w_ch == 3'(c)) r_res[c] <= '0;
            else if (w_mvalid && w_mch == 3'(c)) r_res[c] <= w_mres;
         end
      end
   end
endmodule

// File: tb/tb_scie_fir_mc.sv
// tb_scie_fir_mc: directed checks of the multi-channel FIR, with saturating, truncating and shifting variants
module tb_scie_fir_mc;
   localparam logic [6:0] SET = 7'h0B, PUSH = 7'h2B, READ = 7'h5B, CLR = 7'h7B;
   logic        clock = 1'b0, reset = 1'b1;
   logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
   logic [31:0] insn = '0, rs1 = '0, rs2 = '0;
   logic [31:0] rd0, rd1, rd2;
   int          checks = 0, errors = 0;
   always #5 clock = ~clock;
   scie_fir_mc d0 (.clock(clock), .reset(reset), .io_valid(v0), .io_insn(insn), .io_rs1(rs1), .io_rs2(rs2), .io_rd(rd0));
   scie_fir_mc #(.SATURATE(0)) d1 (.clock(clock), .reset(reset), .io_valid(v1), .io_insn(insn), .io_rs1(rs1), .io_rs2(rs2), .io_rd(rd1));
   scie_fir_mc #(.SHIFT(4)) d2 (.clock(clock), .reset(reset), .io_valid(v2), .io_insn(insn), .io_rs1(rs1), .io_rs2(rs2), .io_rd(rd2));
   task automatic issue(input logic [2:0] m, input logic [6:0] op, input logic [2:0] ch, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      insn = {17'b0, ch, 5'b0, op};
      rs1  = a;
      rs2  = b;
      {v2, v1, v0} = m;
   endtask
   task automatic nop();
      @(negedge clock);
      {v2, v1, v0} = 3'b000;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic rd(input logic [2:0] m, input logic [2:0] ch);
      issue(m, READ, ch, 0, 0);
      nop();
   endtask
   initial begin
      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk("reset_d0", rd0, 0);
      chk("reset_d1", rd1, 0);
      chk("reset_d2", rd2, 0);
      issue(1, SET, 0, 10, 0);
      issue(1, SET, 0, 91, 1);
      issue(1, SET, 0, 85, 2);
      issue(1, SET, 0, 99, 3);
      issue(1, SET, 0, 83, 4);
      issue(1, PUSH, 0, 1, 0); nop(); rd(1, 0);
      chk("basic_push1", rd0, 10);
      issue(1, PUSH, 0, 2, 0); nop(); rd(1, 0);
      chk("basic_push2", rd0, 111);
      issue(1, PUSH, 0, 0, 0); nop(); rd(1, 0);
      chk("basic_push0", rd0, 267);
      issue(1, PUSH, 0, 5, 0);
      issue(1, READ, 0, 0, 0);
      issue(1, READ, 0, 0, 0);
      chk("hazard_t1_old", rd0, 267);
      nop();
      chk("hazard_t2_new", rd0, 319);
      issue(1, SET, 1, 3, 0);
      issue(1, PUSH, 1, 7, 0); nop(); rd(1, 1);
      chk("iso_ch1", rd0, 21);
      rd(1, 0);
      chk("iso_ch0", rd0, 319);
      issue(1, PUSH, 5, 100, 0);
      issue(1, SET, 0, 1000, 9);
      issue(1, 7'h33, 0, 77, 0);
      issue(1, READ, 5, 0, 0);
      nop(); nop();
      chk("noop_hold", rd0, 319);
      issue(1, PUSH, 0, 0, 0); nop(); rd(1, 0);
      chk("noop_state", rd0, 736);
      rd(1, 1);
      chk("noop_ch1", rd0, 21);
      issue(1, SET, 1, 32'h7FFF_FFFF, 0);
      issue(1, CLR, 1, 0, 0);
      issue(1, PUSH, 1, 32'h7FFF_FFFF, 0); nop(); rd(1, 1);
      chk("sat_pos", rd0, 32'h7FFF_FFFF);
      issue(1, PUSH, 1, 32'h8000_0000, 0); nop(); rd(1, 1);
      chk("sat_neg", rd0, 32'h8000_0000);
      issue(2, SET, 0, 32'h7FFF_FFFF, 0);
      issue(2, PUSH, 0, 32'h7FFF_FFFF, 0); nop(); rd(2, 0);
      chk("trunc", rd1, 32'h0000_0001);
      issue(4, SET, 0, 16, 0);
      issue(4, PUSH, 0, 3, 0); nop(); rd(4, 0);
      chk("shift_pos", rd2, 3);
      issue(4, PUSH, 0, 32'hFFFF_FFFB, 0); nop(); rd(4, 0);
      chk("shift_neg", rd2, 32'hFFFF_FFFB);
      issue(1, PUSH, 0, 9, 0);
      issue(1, CLR, 0, 0, 0);
      nop();
      rd(1, 0);
      chk("clear_race", rd0, 0);
      issue(1, PUSH, 0, 5, 0); nop(); rd(1, 0);
      chk("clear_line", rd0, 50);
      rd(1, 1);
      chk("clear_other_ch", rd0, 32'h8000_0000);
      issue(1, PUSH, 0, 7, 0);
      @(negedge clock);
      {v2, v1, v0} = 3'b000;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midreset_rd", rd0, 0);
      nop(); nop();
      rd(1, 0);
      chk("midreset_res", rd0, 0);
      issue(1, PUSH, 0, 4, 0); nop(); rd(1, 0);
      chk("midreset_coef", rd0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
